// File: rtl/hz_pkg.sv
// Shared definitions for the Hz counter / tone generator pair.
package hz_pkg;

  localparam int unsigned DEFAULT_CLK_HZ  = 100_000_000;
  localparam int unsigned HZ_W            = 10;
  localparam int unsigned DEFAULT_BURST_W = 10;
  localparam int unsigned DEFAULT_DIV_W   = 27;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    RUN    = 2'd2,
    FINISH = 2'd3
  } hz_state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider: one quotient bit per clk, then one clk to latch.
module seq_divider #(
  parameter int unsigned DVD_W = 27,
  parameter int unsigned DVS_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVD_W-1:0] quotient,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(DVD_W + 1);

  logic [DVD_W-1:0] dvd_sh;
  logic [DVD_W-1:0] q_sh;
  logic [DVS_W-1:0] dvs;
  logic [DVS_W-1:0] rem;
  logic [CNT_W-1:0] cnt;
  logic [DVS_W:0]   trial_c;
  logic             fits_c;

  // Partial remainder with the next dividend bit shifted in, and the restore decision.
  assign trial_c = {rem, dvd_sh[DVD_W-1]};
  assign fits_c  = (trial_c >= {1'b0, dvs});

  // Iterate DVD_W steps, then present the quotient with a done pulse; start restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_sh   <= '0;
      q_sh     <= '0;
      dvs      <= '0;
      rem      <= '0;
      cnt      <= '0;
      quotient <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else if (start) begin
        dvd_sh <= dividend;
        dvs    <= divisor;
        rem    <= '0;
        q_sh   <= '0;
        cnt    <= '0;
        busy   <= 1'b1;
      end else if (busy) begin
        if (cnt == CNT_W'(DVD_W)) begin
          quotient <= q_sh;
          done     <= 1'b1;
          busy     <= 1'b0;
        end else begin
          dvd_sh <= dvd_sh << 1;
          q_sh   <= {q_sh[DVD_W-2:0], fits_c};
          rem    <= fits_c ? DVS_W'(trial_c - {1'b0, dvs}) : DVS_W'(trial_c);
          cnt    <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/hz_tone_generator.sv
// 50%-duty square-wave tone source driven by a binary Hz request.
// Optional: define TONE_SYNC_OUT_EN to add tone_sync, a pulse on every JA2 rise.
module hz_tone_generator #(
  parameter int unsigned CLK_HZ  = hz_pkg::DEFAULT_CLK_HZ,
  parameter int unsigned HZ_W    = hz_pkg::HZ_W,
  parameter int unsigned BURST_W = hz_pkg::DEFAULT_BURST_W,
  parameter int unsigned DIV_W   = hz_pkg::DEFAULT_DIV_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [HZ_W-1:0]    freq_hz,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               start,
  input  logic               update,
  input  logic               stop,
  output logic               JA2,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] cycles_sent
`ifdef TONE_SYNC_OUT_EN
  ,
  output logic               tone_sync
`endif
);

  import hz_pkg::*;

  localparam logic [DIV_W-1:0] DIVIDEND = DIV_W'(CLK_HZ / 2);

  hz_state_t          state, state_nxt;
  logic               ja2_nxt, done_nxt, busy_nxt;
  logic [BURST_W-1:0] cyc_nxt, cyc_inc_c, burst_q, burst_nxt;
  logic [DIV_W-1:0]   half_q, half_nxt, phase_q, phase_nxt;
  logic [DIV_W-1:0]   pend_half, pend_half_nxt;
  logic               pend_v, pend_v_nxt;
  logic [DIV_W-1:0]   div_q, div_half_c;
  logic               div_start_c, div_abort_c, div_busy, div_done;
  logic               at_end_c;

  seq_divider #(
    .DVD_W (DIV_W),
    .DVS_W (HZ_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start_c),
    .abort    (div_abort_c),
    .dividend (DIVIDEND),
    .divisor  (freq_hz),
    .quotient (div_q),
    .busy     (div_busy),
    .done     (div_done)
  );

  // Half-period clamped to at least one clk; end-of-half detect; saturating cycle count.
  assign div_half_c = (div_q == '0) ? DIV_W'(1) : div_q;
  assign at_end_c   = (phase_q == half_q - DIV_W'(1));
  assign cyc_inc_c  = (cycles_sent == '1) ? cycles_sent : cycles_sent + BURST_W'(1);

  // Next-state and next-output decode; retunes apply only at the start of a new high half.
  always_comb begin
    state_nxt     = state;
    ja2_nxt       = JA2;
    done_nxt      = 1'b0;
    cyc_nxt       = cycles_sent;
    burst_nxt     = burst_q;
    half_nxt      = half_q;
    phase_nxt     = phase_q;
    pend_v_nxt    = pend_v;
    pend_half_nxt = pend_half;
    div_start_c   = 1'b0;
    div_abort_c   = 1'b0;
    case (state)
      IDLE: begin
        if (start && (freq_hz != '0)) begin
          burst_nxt   = burst_len;
          cyc_nxt     = '0;
          pend_v_nxt  = 1'b0;
          div_start_c = 1'b1;
          state_nxt   = CALC;
        end
      end
      CALC: begin
        if (stop) begin
          div_abort_c = div_busy;
          done_nxt    = 1'b1;
          ja2_nxt     = 1'b0;
          cyc_nxt     = '0;
          state_nxt   = IDLE;
        end else if (div_done) begin
          half_nxt  = div_half_c;
          phase_nxt = '0;
          ja2_nxt   = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN, FINISH: begin
        if (state == RUN) begin
          if (stop) begin
            state_nxt = FINISH;
          end else if (update && (freq_hz != '0)) begin
            div_start_c = 1'b1;
          end
        end
        if (at_end_c) begin
          phase_nxt = '0;
          if (JA2) begin
            ja2_nxt = 1'b0;
            cyc_nxt = cyc_inc_c;
            if ((burst_q != '0) && (cyc_inc_c == burst_q)) begin
              done_nxt  = 1'b1;
              state_nxt = IDLE;
            end
          end else if (state == FINISH) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            ja2_nxt = 1'b1;
            if (pend_v) begin
              half_nxt   = pend_half;
              pend_v_nxt = 1'b0;
            end
          end
        end else begin
          phase_nxt = phase_q + DIV_W'(1);
        end
        if (state_nxt == IDLE) begin
          div_start_c = 1'b0;
          div_abort_c = div_busy;
          pend_v_nxt  = 1'b0;
        end else if ((state == RUN) && div_done) begin
          pend_v_nxt    = 1'b1;
          pend_half_nxt = div_half_c;
        end
      end
      default: begin
        state_nxt = IDLE;
        ja2_nxt   = 1'b0;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers; reset drops JA2 immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      JA2         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cycles_sent <= '0;
      burst_q     <= '0;
      half_q      <= DIV_W'(1);
      phase_q     <= '0;
      pend_v      <= 1'b0;
      pend_half   <= '0;
    end else begin
      state       <= state_nxt;
      JA2         <= ja2_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      cycles_sent <= cyc_nxt;
      burst_q     <= burst_nxt;
      half_q      <= half_nxt;
      phase_q     <= phase_nxt;
      pend_v      <= pend_v_nxt;
      pend_half   <= pend_half_nxt;
    end
  end

`ifdef TONE_SYNC_OUT_EN
  // Trigger pulse aligned with each JA2 rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_sync <= 1'b0;
    end else begin
      tone_sync <= ja2_nxt & ~JA2;
    end
  end
`endif

endmodule

// File: tb/tb_hz_tone_generator.sv
// Bench for hz_tone_generator: edge timestamps compared against Hz arithmetic.
module tb_hz_tone_generator;

  localparam int unsigned CLK_HZ  = 1000;
  localparam int unsigned HZ_W    = 10;
  localparam int unsigned BURST_W = 10;
  localparam int unsigned DIV_W   = 27;
  localparam int          LAT     = DIV_W + 2;

  logic               clk;
  logic               rst_n;
  logic [HZ_W-1:0]    freq_hz;
  logic [BURST_W-1:0] burst_len;
  logic               start, update, stop;
  logic               JA2, busy, done;
  logic [BURST_W-1:0] cycles_sent;
`ifdef TONE_SYNC_OUT_EN
  logic               tone_sync;
  int                 sync_err = 0;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rise_q[$];
  int fall_q[$];
  int done_q[$];
  logic prev_ja2 = 1'b0;

  hz_tone_generator #(
    .CLK_HZ  (CLK_HZ),
    .HZ_W    (HZ_W),
    .BURST_W (BURST_W),
    .DIV_W   (DIV_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .freq_hz     (freq_hz),
    .burst_len   (burst_len),
    .start       (start),
    .update      (update),
    .stop        (stop),
    .JA2         (JA2),
    .busy        (busy),
    .done        (done),
    .cycles_sent (cycles_sent)
`ifdef TONE_SYNC_OUT_EN
    ,
    .tone_sync   (tone_sync)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Timestamp every JA2 edge and done pulse, in posedge counts.
  always @(negedge clk) begin
    if (JA2 && !prev_ja2) rise_q.push_back(cyc);
    if (!JA2 && prev_ja2) fall_q.push_back(cyc);
    if (done) done_q.push_back(cyc);
`ifdef TONE_SYNC_OUT_EN
    if (tone_sync !== (JA2 && !prev_ja2)) sync_err <= sync_err + 1;
`endif
    prev_ja2 <= JA2;
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_half(input int f);
    int h;
    h = CLK_HZ / (2 * f);
    return (h < 1) ? 1 : h;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_tone(input int f, input int n, output int s);
    freq_hz   = HZ_W'(f);
    burst_len = BURST_W'(n);
    start     = 1'b1;
    s         = cyc + 1;
    tick();
    start     = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        chk({tag, "_busy_at_done"}, busy, 0);
      end
    end
    if (!seen) chk({tag, "_done_timeout"}, 0, 1);
  endtask

  task automatic wait_rises(input string tag, input int base, input int n, input int limit);
    int i;
    i = 0;
    while ((rise_q.size() - base) < n && i < limit) begin
      tick();
      i++;
    end
    if ((rise_q.size() - base) < n) chk({tag, "_rise_timeout"}, rise_q.size() - base, n);
  endtask

  task automatic check_burst(input string tag, input int f, input int n, input int s,
                             input int br, input int bf, input int bd);
    int h;
    h = model_half(f);
    chk({tag, "_rises"}, rise_q.size() - br, n);
    chk({tag, "_falls"}, fall_q.size() - bf, n);
    chk({tag, "_dones"}, done_q.size() - bd, 1);
    if ((rise_q.size() - br) == n && (fall_q.size() - bf) == n && (done_q.size() - bd) == 1) begin
      chk({tag, "_latency"}, rise_q[br] - s, LAT);
      for (int i = 0; i < n; i++) begin
        chk({tag, "_high"}, fall_q[bf+i] - rise_q[br+i], h);
        if (i < n - 1) chk({tag, "_low"}, rise_q[br+i+1] - fall_q[bf+i], h);
      end
      chk({tag, "_done_at_last_fall"}, done_q[bd], fall_q[bf+n-1]);
    end
    chk({tag, "_cycles_sent"}, cycles_sent, n);
    chk({tag, "_ja2_idle"}, JA2, 0);
  endtask

  initial begin
    int s, br, bf, bd, f, n, r, c0, nout, nasym;
    int hi[6];
    int lo[6];
    rst_n = 1'b0; start = 1'b0; update = 1'b0; stop = 1'b0;
    freq_hz = '0; burst_len = '0;
    tick(); tick();
    chk("reset_ja2", JA2, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_cycles", cycles_sent, 0);
    rst_n = 1'b1;
    tick();

    // 5 Hz burst of 3
    br = rise_q.size(); bf = fall_q.size(); bd = done_q.size();
    start_tone(5, 3, s);
    wait_done("burst5", LAT + 700);
    check_burst("burst5", 5, 3, s, br, bf, bd);
    tick();

    // randomized bursts
    for (int k = 0; k < 6; k++) begin
      f = $urandom_range(40, 3);
      n = $urandom_range(4, 1);
      br = rise_q.size(); bf = fall_q.size(); bd = done_q.size();
      start_tone(f, n, s);
      wait_done("rnd", LAT + 2 * model_half(f) * n + 50);
      check_burst("rnd", f, n, s, br, bf, bd);
      tick();
    end

    // highest frequency clamps to 1-clk halves
    br = rise_q.size(); bf = fall_q.size(); bd = done_q.size();
    start_tone(1023, 2, s);
    wait_done("clamp", LAT + 50);
    check_burst("clamp", 1023, 2, s, br, bf, bd);
    tick();

    // continuous 3 Hz, with an ignored start mid-run
    br = rise_q.size(); bf = fall_q.size(); bd = done_q.size();
    start_tone(3, 0, s);
    wait_rises("cont3", br, 2, 1000);
    freq_hz = 10'd5; start = 1'b1; tick(); start = 1'b0;
    wait_rises("cont3", br, 4, 1500);
    if ((rise_q.size() - br) >= 4 && (fall_q.size() - bf) >= 3) begin
      chk("cont3_latency", rise_q[br] - s, LAT);
      for (int i = 0; i < 3; i++) chk("cont3_high", fall_q[bf+i] - rise_q[br+i], 166);
      for (int i = 0; i < 2; i++) chk("cont3_fall_spacing", fall_q[bf+i+1] - fall_q[bf+i], 332);
    end
    chk("cont3_cycles", cycles_sent, 3);
    chk("cont3_no_done", done_q.size() - bd, 0);
    pulse_stop();
    wait_done("cont3_stop", 800);
    chk("cont3_one_done", done_q.size() - bd, 1);
    chk("cont3_ja2_off", JA2, 0);
    tick();

    // stop 30 clks into a high half; zero-Hz update ignored
    br = rise_q.size(); bf = fall_q.size(); bd = done_q.size();
    start_tone(5, 0, s);
    wait_rises("stop5", br, 2, 1000);
    r = (rise_q.size() - br >= 2) ? rise_q[br+1] : cyc;
    while (cyc < r + 9) tick();
    freq_hz = '0; update = 1'b1; tick(); update = 1'b0;
    while (cyc < r + 29) tick();
    c0 = cycles_sent;
    pulse_stop();
    wait_done("stop5", 400);
    chk("stop5_cycles_before", c0, 1);
    chk("stop5_cycles_after", cycles_sent, 2);
    chk("stop5_fall", (fall_q.size() > bf + 1) ? fall_q[bf+1] : -1, r + 100);
    chk("stop5_done", (done_q.size() > bd) ? done_q[bd] : -1, r + 200);
    chk("stop5_no_extra_rise", rise_q.size() - br, 2);
    chk("stop5_ja2", JA2, 0);
    tick();

    // retune 5 Hz -> 10 Hz in the middle of a high half
    br = rise_q.size(); bf = fall_q.size(); bd = done_q.size();
    start_tone(5, 0, s);
    wait_rises("upd", br, 2, 1000);
    r = (rise_q.size() - br >= 2) ? rise_q[br+1] : cyc;
    while (cyc < r + 29) tick();
    freq_hz = 10'd10; update = 1'b1; tick(); update = 1'b0;
    wait_rises("upd", br, 6, 1500);
    pulse_stop();
    wait_done("upd", 400);
    if ((rise_q.size() - br) == 6 && (fall_q.size() - bf) == 6 && (done_q.size() - bd) == 1) begin
      nout = 0; nasym = 0;
      for (int i = 0; i < 6; i++) begin
        hi[i] = fall_q[bf+i] - rise_q[br+i];
        lo[i] = (i < 5) ? rise_q[br+i+1] - fall_q[bf+i] : done_q[bd] - fall_q[bf+i];
        if (hi[i] != 50 && hi[i] != 100) nout++;
        if (lo[i] != 50 && lo[i] != 100) nout++;
        if (hi[i] != lo[i]) nasym++;
      end
      chk("upd_high_at_update", hi[1], 100);
      chk("upd_low_at_update", lo[1], 100);
      chk("upd_first_new_high", hi[2], 50);
      chk("upd_last_low", lo[5], 50);
      chk("upd_out_of_set", nout, 0);
      chk("upd_asym_period", nasym, 0);
    end else begin
      chk("upd_edge_count", rise_q.size() - br, 6);
    end
    tick();

    // start with zero frequency is ignored
    bd = done_q.size(); br = rise_q.size();
    start_tone(0, 2, s);
    for (int i = 0; i < 50; i++) tick();
    chk("zero_busy", busy, 0);
    chk("zero_ja2", JA2, 0);
    chk("zero_no_done", done_q.size() - bd, 0);
    chk("zero_no_rise", rise_q.size() - br, 0);

    // stop while the divider runs
    br = rise_q.size(); bd = done_q.size();
    start_tone(5, 0, s);
    while (cyc < s + 9) tick();
    pulse_stop();
    for (int i = 0; i < 60; i++) tick();
    chk("calc_stop_done_count", done_q.size() - bd, 1);
    chk("calc_stop_done_at", (done_q.size() > bd) ? done_q[bd] : -1, s + 10);
    chk("calc_stop_cycles", cycles_sent, 0);
    chk("calc_stop_busy", busy, 0);
    chk("calc_stop_no_rise", rise_q.size() - br, 0);

    // reset in the middle of a high half
    br = rise_q.size();
    start_tone(5, 0, s);
    wait_rises("rst", br, 2, 1000);
    for (int i = 0; i < 20; i++) tick();
    chk("rst_pre_ja2", JA2, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_ja2", JA2, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cycles", cycles_sent, 0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    br = rise_q.size(); bf = fall_q.size(); bd = done_q.size();
    start_tone(5, 1, s);
    wait_done("post_rst", LAT + 300);
    check_burst("post_rst", 5, 1, s, br, bf, bd);

`ifdef TONE_SYNC_OUT_EN
    chk("tone_sync_err", sync_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
